// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, execute redirect and decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        output opcode, funct3, funct7, fetch_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        input  opcode, funct3, funct7, fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/gnt/rvalid fetch port, IR with valid/ready to decode.
// Define IFETCH_MISALIGN_CHK_EN to fault on redirect targets with pc[1:0] != 0.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     MAX_WAIT = 15
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned CW  = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_valid;
    logic            r_fault;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_drop;

    logic [XLEN-1:0] w_redir_pc;
    logic            w_misalign;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign w_redir_pc = bus.redirect_pc;
    assign w_misalign = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^bus.redirect_pc[1:0];
    assign w_redir_pc   = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign w_misalign   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= NOP;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_wait_cnt <= '0;
            r_drop     <= 1'b0;
        end else if (w_misalign) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (bus.redirect) r_pc <= w_redir_pc;
                    // drop marks the single outstanding response as stale
                    if (bus.imem_gnt) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                        r_drop     <= bus.redirect |
                                      (r_drop & ~bus.imem_rvalid);
                    end else if (bus.imem_rvalid) begin
                        r_drop <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect) begin
                        r_pc    <= w_redir_pc;
                        r_drop  <= ~bus.imem_rvalid;
                        r_state <= S_REQ;
                    end else if (bus.imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_ir       <= bus.imem_rdata;
                            r_instr_pc <= r_pc;
                            r_pc       <= r_pc + XLEN'(4);
                            r_valid    <= 1'b1;
                            r_state    <= S_HOLD;
                        end
                    end else if (r_wait_cnt == CW'(MAX_WAIT)) begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_redir_pc;
                        r_state <= S_REQ;
                    end else if (bus.instr_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                S_FAULT: begin
                    r_valid <= 1'b0;
                    r_state <= S_FAULT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req    = (r_state == S_REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr       = r_ir;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.opcode      = r_ir[6:0];
    assign bus.funct3      = r_ir[14:12];
    assign bus.funct7      = r_ir[31:25];
    assign bus.fetch_fault = r_fault;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected IR words,
// a negedge monitor pops and compares on every decode handshake.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    bit          gnt_en = 1'b0;
    bit          mute = 1'b0;
    int          lat = 0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0020_8033 ^ {a[23:0], 8'h00};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void push(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        expq.push_back(e);
    endfunction

    // memory model: drives gnt/rvalid 1ns after each rising edge
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    if (!mute) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_word(paddr);
                    end
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            bus.imem_gnt = bus.imem_req && gnt_en;
            if (bus.imem_gnt) begin
                pend  = 1'b1;
                paddr = bus.imem_addr;
                pcnt  = lat;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.instr_valid && bus.instr_ready) begin
                hs_cnt++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr actual=%h required=none",
                             bus.instr_pc);
                end else begin
                    e = expq.pop_front();
                    chk("instr", bus.instr, e.ins);
                    chk("instr_pc", bus.instr_pc, e.pc);
                    chk("opcode", 32'(bus.opcode), 32'(e.ins[6:0]));
                    chk("funct3", 32'(bus.funct3), 32'(e.ins[14:12]));
                    chk("funct7", 32'(bus.funct7), 32'(e.ins[31:25]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic consume(input int n);
        int target;
        bit ok;
        target = hs_cnt + n;
        ok = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (hs_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        bus.instr_ready = 1'b0;
        chk("consume_done", 32'(ok), 32'd1);
    endtask

    task automatic wait_gnt();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (bus.imem_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        chk("gnt_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;

        @(negedge clk);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_instr", bus.instr, 32'h0000_0013);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fault", 32'(bus.fetch_fault), 32'd0);

        cyc();
        rst_n  = 1'b1;
        gnt_en = 1'b1;
        lat    = 0;
        push(32'h0, 32'h0020_8033);
        push(32'h4, 32'h0020_8433);
        push(32'h8, 32'h0020_8833);
        consume(3);

        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("hold_valid_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_instr", bus.instr, 32'h0020_8C33);
            chk("stall_pc", bus.instr_pc, 32'hC);
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        cyc();
        gnt_en = 1'b0;
        push(32'hC, 32'h0020_8C33);
        consume(1);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        cyc();
        bus.redirect = 1'b0;
        chk("req_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("req_redir_req", 32'(bus.imem_req), 32'd1);
        gnt_en = 1'b1;
        wait_gnt();
        gnt_en = 1'b0;
        push(32'hFFFF_FFFC, 32'hFFDF_7C33);
        consume(1);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_fault", 32'(bus.fetch_fault), 32'd0);

        lat    = 2;
        gnt_en = 1'b1;
        wait_gnt();
        gnt_en = 1'b0;
        cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        cyc();
        bus.redirect = 1'b0;
        repeat (3) cyc();
        chk("drop_valid", 32'(bus.instr_valid), 32'd0);
        chk("drop_req", 32'(bus.imem_req), 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h100);
        lat    = 0;
        gnt_en = 1'b1;
        wait_gnt();
        gnt_en = 1'b0;
        push(32'h100, 32'h0021_8033);
        consume(1);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h102;
        cyc();
        bus.redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("misalign_fault", 32'(bus.fetch_fault), 32'd1);
        chk("misalign_req", 32'(bus.imem_req), 32'd0);
`else
        chk("align_addr", bus.imem_addr, 32'h100);
        chk("align_fault", 32'(bus.fetch_fault), 32'd0);
`endif

        rst_n = 1'b0;
        #1;
        chk("rst2_fault", 32'(bus.fetch_fault), 32'd0);
        chk("rst2_req", 32'(bus.imem_req), 32'd0);
        chk("rst2_valid", 32'(bus.instr_valid), 32'd0);
        mute   = 1'b1;
        lat    = 0;
        gnt_en = 1'b1;
        cyc();
        rst_n = 1'b1;
        wait_gnt();
        repeat (15) cyc();
        chk("tmo_early_fault", 32'(bus.fetch_fault), 32'd0);
        repeat (2) cyc();
        chk("tmo_fault", 32'(bus.fetch_fault), 32'd1);
        mute = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("tmo_req", 32'(bus.imem_req), 32'd0);
            chk("tmo_valid", 32'(bus.instr_valid), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("tmo_rst_fault", 32'(bus.fetch_fault), 32'd0);

        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
